// File: rtl/sd_audio_pkg.sv
// Shared types and width helpers for the sigma-delta audio mixer.
package sd_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_LOAD
    } state_e;

    function automatic int dw_f(input int w);
        return w + 1;
    endfunction

    function automatic int accw_f(input int w, input int vw, input int nch);
        return w + vw + $clog2(nch);
    endfunction

endpackage

// File: rtl/sd_dac_1st.sv
// First-order sigma-delta modulator; the carry out of the phase
// accumulator is the output bit.
module sd_dac_1st
    import sd_audio_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [DW-1:0] din,
    output logic          dout
);

    localparam logic [DW:0] ACC_RST = (DW+1)'(2 ** (DW - 1));

    logic [DW:0] acc_q;
    logic [DW:0] acc_d;

    assign acc_d = {1'b0, acc_q[DW-1:0]} + {1'b0, din};

    // The top bit of the registered sum doubles as the output register.
    assign dout = acc_q[DW];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q <= ACC_RST;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sd_audio_mixer.sv
// Sequential multi-channel volume mixer feeding a stereo pair of
// sigma-delta DACs.
module sd_audio_mixer
    import sd_audio_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int VW  = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            sample_stb,
    input  logic [NCH*W-1:0]  ch_data,
    input  logic [NCH*VW-1:0] vol_l,
    input  logic [NCH*VW-1:0] vol_r,
    output logic            busy,
    output logic            sample_done,
    output logic            overrun,
    output logic            audio_left,
    output logic            audio_right
);

    localparam int DW  = dw_f(W);
    localparam int PW  = W + VW;
    localparam int AW  = accw_f(W, VW, NCH);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NP  = 2 ** IW;
    localparam logic [AW-1:0] SAT  = AW'((2 ** DW) - 1);
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    state_e              state_q;
    logic [IW-1:0]       idx_q;
    logic [NP*W-1:0]     ch_q;
    logic [NP*VW-1:0]    vl_q;
    logic [NP*VW-1:0]    vr_q;
    logic [AW-1:0]       acc_l_q;
    logic [AW-1:0]       acc_r_q;
    logic [DW-1:0]       held_l_q;
    logic [DW-1:0]       held_r_q;
    logic                busy_q;
    logic                done_q;
    logic                ovr_q;

    logic [W-1:0]        ch_cur;
    logic [VW-1:0]       vl_cur;
    logic [VW-1:0]       vr_cur;
    logic [PW-1:0]       prod_l;
    logic [PW-1:0]       prod_r;
    logic [AW-1:0]       s_l;
    logic [AW-1:0]       s_r;
    logic [DW-1:0]       held_l_d;
    logic [DW-1:0]       held_r_d;

    // Shadows are padded to a power of two so any index stays in range.
    assign ch_cur = ch_q[idx_q*W +: W];
    assign vl_cur = vl_q[idx_q*VW +: VW];
    assign vr_cur = vr_q[idx_q*VW +: VW];
    assign prod_l = PW'(ch_cur) * PW'(vl_cur);
    assign prod_r = PW'(ch_cur) * PW'(vr_cur);

    assign s_l = acc_l_q >> VW;
    assign s_r = acc_r_q >> VW;
    assign held_l_d = (s_l > SAT) ? SAT[DW-1:0] : s_l[DW-1:0];
    assign held_r_d = (s_r > SAT) ? SAT[DW-1:0] : s_r[DW-1:0];

    assign busy        = busy_q;
    assign sample_done = done_q;
    assign overrun     = ovr_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            ch_q     <= '0;
            vl_q     <= '0;
            vr_q     <= '0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            held_l_q <= '0;
            held_r_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= sample_stb && busy_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (sample_stb) begin
                        ch_q    <= (NP*W)'(ch_data);
                        vl_q    <= (NP*VW)'(vol_l);
                        vr_q    <= (NP*VW)'(vol_r);
                        acc_l_q <= '0;
                        acc_r_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_l_q <= acc_l_q + AW'(prod_l);
                    acc_r_q <= acc_r_q + AW'(prod_r);
                    if (idx_q == LAST) begin
                        state_q <= ST_LOAD;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    held_l_q <= held_l_d;
                    held_r_q <= held_r_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sd_dac_1st #(.DW(DW)) u_dac_l (
        .Clk   (Clk),
        .Reset (Reset),
        .din   (held_l_q),
        .dout  (audio_left)
    );

    sd_dac_1st #(.DW(DW)) u_dac_r (
        .Clk   (Clk),
        .Reset (Reset),
        .din   (held_r_q),
        .dout  (audio_right)
    );

endmodule

// File: doc/sd_audio_mixer.md
SD_AUDIO_MIXER -- requirements
Module: sd_audio_mixer

Interface
REQ-001 Parameter NCH, default 4: number of mixed input channels, 1..16.
REQ-002 Parameter W, default 8: width of each unsigned channel sample.
REQ-003 Parameter VW, default 4: width of each per-channel volume; gain = vol / 2**VW.
REQ-004 Derived constant DW = W+1: width of the held DAC sample.
REQ-005 Port Clk, input, 1: single clock for all state.
REQ-006 Port Reset, input, 1: asynchronous, active-high reset.
REQ-007 Port sample_stb, input, 1: one-cycle request to mix a new sample.
REQ-008 Port ch_data, input, NCH*W: unsigned channel samples; channel i occupies bits [i*W +: W].
REQ-009 Port vol_l, input, NCH*VW: left volume per channel, same packing as ch_data.
REQ-010 Port vol_r, input, NCH*VW: right volume per channel, same packing as ch_data.
REQ-011 Port busy, output, 1: high while a mix is in progress.
REQ-012 Port sample_done, output, 1: one-cycle pulse when the held samples update.
REQ-013 Port overrun, output, 1: one-cycle pulse when sample_stb is dropped.
REQ-014 Port audio_left, output, 1: registered sigma-delta bitstream, left channel.
REQ-015 Port audio_right, output, 1: registered sigma-delta bitstream, right channel.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACC and LOAD.
REQ-017 In IDLE, sample_stb=1 SHALL capture ch_data, vol_l and vol_r into shadow registers, clear both accumulators, set the channel index to 0 and enter ACC.
REQ-018 ACC SHALL add ch[i]*vol_l[i] and ch[i]*vol_r[i] to the left and right accumulators each cycle, then increment i.
REQ-019 Products SHALL be W+VW bits; accumulators SHALL be W+VW+clog2(NCH) bits, so no overflow is possible.
REQ-020 ACC SHALL enter LOAD after the cycle with i = NCH-1 and SHALL not wrap the index.
REQ-021 LOAD SHALL compute s = acc >> VW per side and saturate s to 2**DW-1 when s >= 2**DW.
REQ-022 LOAD SHALL write the saturated values into held_l and held_r, pulse sample_done for that cycle, and return to IDLE.
REQ-023 Latency: sample_stb at cycle t SHALL cause held_l/held_r to update and sample_done to pulse at t+NCH+1.
REQ-024 busy SHALL be 1 in ACC and LOAD and 0 in IDLE.
REQ-025 sample_stb while busy=1 SHALL be ignored and SHALL pulse overrun in the same cycle.
REQ-026 Input changes after capture SHALL NOT affect the mix in progress.
REQ-027 Each DAC side SHALL be a first-order sigma-delta modulator with a DW+1 bit accumulator.
REQ-028 Each clock, the DAC SHALL compute sum = {0, acc[DW-1:0]} + held, load acc <= sum, and register the output as sum[DW].
REQ-029 For a constant held = x, the output SHALL contain exactly x ones in every 2**DW consecutive cycles.
REQ-030 A held-value change SHALL take effect in the DAC on the cycle after LOAD, with no glitch or restart of the modulator.

Reset
REQ-031 Reset SHALL asynchronously force state IDLE, index 0, accumulators 0 and held_l = held_r = 0.
REQ-032 Reset SHALL force both DAC accumulators to 2**(DW-1) and all outputs (busy, sample_done, overrun, audio_left, audio_right) to 0.
REQ-033 Reset asserted mid-ACC or mid-LOAD SHALL abort the mix; no sample_done SHALL follow after release.

Structure
REQ-034 Package sd_audio_pkg SHALL hold the FSM state encoding and the DW and accumulator-width derivation functions.
REQ-035 The modulator SHALL be a sub-module sd_dac_1st (parameter DW, ports Clk, Reset, din, dout), instantiated twice.

Verification
REQ-036 Single-channel DC: ch0=255, vol_l0=15, all others 0, one strobe -> sample_done at cycle t+5 and held_l=239; audio_left has 239 ones in a 512-cycle window; held_r=0 and audio_right stays 0.
REQ-037 Saturation: all channels 255, all volumes 15 -> held_l = held_r = 511, and each output has 511 ones per 512 cycles.
REQ-038 Overrun: strobes at t and t+2 -> overrun pulses at t+2, exactly one sample_done occurs, and busy is high t+1..t+5.
REQ-039 Capture isolation: change ch_data at t+1 after a strobe at t -> held values reflect the data captured at t.
REQ-040 Reset mid-mix: assert Reset at t+2 -> all outputs 0 immediately; no sample_done follows; the DAC accumulators restart at 256.
REQ-041 Parameter sweep: NCH=1,W=8 and NCH=8,W=12 -> latency NCH+1 holds, and the density law of REQ-029 holds for held = 0, 1 and 2**DW-1.
